queue_stream_reader: RTL
========================

# queue_stream_reader

Drains the byte-wide SRAM event queue and presents its contents as a valid/ready stream to the downstream consumer. It issues read pulses to the queue only when buffer space is guaranteed and absorbs the SRAM's one-cycle read latency in a small output FIFO. It also suppresses reads in cycles where the queue is inserting, because a write has priority over a read inside the queue. The block sits directly downstream of the queue and upstream of the event-processing logic.

## Interface
- DATA_W, 8, event width; equals the queue data width.
- DEPTH, 2, output FIFO entries; minimum 2 for one event per cycle.
- CNT_W, 16, width of the delivered-event counter.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  drain enable; when low, no new reads are issued.
- q_valid_i  in  1  queue non-empty (the queue's valid output).
- q_insert_i  in  1  queue insert strobe, same cycle as the queue sees it.
- q_data_i  in  DATA_W  queue read data (SRAM read port).
- q_read_o  out  1  read strobe to the queue.
- m_valid_o  out  1  output event valid.
- m_ready_i  in  1  downstream accept.
- m_data_o  out  DATA_W  output event.
- busy_o  out  1  a read is in flight or the FIFO is non-empty.
- count_o  out  CNT_W  number of events delivered since reset.

## Operation
- Reset is synchronous and active-high on rst; the clock is clk.
- Internal state:
  - `inflight`: 1 bit, set when a read was issued in the previous cycle.
  - `occ`: 0..DEPTH, FIFO occupancy.
  - FIFO storage.
  - `count`.
- pop = m_valid_o & m_ready_i.
- q_read_o = en_i & q_valid_i & ~q_insert_i & (occ + inflight - pop < DEPTH). It is combinational from registers and inputs.
  - Arithmetic uses clog2(DEPTH)+2 bits, so the expression cannot underflow.
- Accepted read: the cycle with q_read_o=1 sets `inflight`. In the following cycle q_data_i is written into the FIFO tail at the clock edge, and `inflight` clears unless a new read is issued.
- m_valid_o = (occ != 0). m_data_o = FIFO head, registered storage, not the SRAM output directly.
- pop removes the head; push and pop in the same cycle leave occ unchanged.
- count increments by 1 on each pop and wraps modulo 2^CNT_W.
- busy_o = inflight | (occ != 0).
- en_i deasserted mid-stream:
  - An in-flight read still completes into the FIFO.
  - Buffered data is still delivered.
  - No new reads are issued.
- Insert/read collision: q_insert_i=1 forces q_read_o=0. The read is retried in the next cycle if the other conditions still hold. A read is never dropped.
- Empty queue (q_valid_i=0): no read is issued. The FIFO drains normally.
- Full FIFO with m_ready_i=0: reads stop once occ + inflight reaches DEPTH. The FIFO never overflows.
- Reset mid-operation:
  - occ, inflight and count all clear.
  - Any in-flight SRAM data is discarded, not captured.
  - The queue is reset by the same rst, so no events are duplicated.

## Timing
- Reset values: q_read_o=0, m_valid_o=0, m_data_o=0, busy_o=0, count_o=0.
- Latency: read issued in cycle N, event visible on m_valid_o/m_data_o in cycle N+2. That is one SRAM cycle plus one FIFO register.
- Throughput: one event per cycle when q_valid_i=1, q_insert_i=0 and m_ready_i=1, with DEPTH>=2.
- m_valid_o is not withdrawn and m_data_o is held stable until a pop.
- q_read_o may depend combinationally on m_ready_i. Downstream must not make m_ready_i depend combinationally on q_read_o.

## Structure
- Shared package holds:
  - `EVT_W`, equal to 8; DATA_W defaults to it.
  - The `evt_t` typedef.
  - `CNT_W`.
- One sub-module: `evt_fifo`, a synchronous DEPTH-entry FIFO with push, pop, occ and head output, reset-clearable. Read-issue logic, `inflight` and the counter stay in the top module.

## Test plan
- Back-to-back drain: queue holds 0x11,0x22,0x33, m_ready_i=1, en_i=1. Required: m_data_o 0x11,0x22,0x33 on three consecutive cycles starting 2 cycles after the first q_read_o; count_o=3; busy_o falls after the last pop.
- Collision: q_insert_i=1 in the cycle q_read_o would assert. Required: q_read_o=0 that cycle and =1 the next; no event lost or duplicated; order preserved.
- Backpressure: 5 events queued, m_ready_i=0. Required: exactly 2 reads issued, m_valid_o=1 holding the first event stable. Release m_ready_i: all 5 delivered in order.
- Enable gating: deassert en_i one cycle after a read. Required: that event is still delivered and no further q_read_o occurs. Reassert en_i: draining resumes.
- Reset mid-flight: assert rst in the cycle after q_read_o. Required: next cycle m_valid_o=0, busy_o=0, count_o=0, and the in-flight byte is never output.
- Counter wrap: deliver 65537 events (CNT_W=16). Required: count_o=1.

Source files
------------

// File: rtl/queue_stream_reader_pkg.sv
// Shared types and widths for the event-queue stream reader.
package queue_stream_reader_pkg;
  localparam int EVT_W = 8;
  localparam int CNT_W = 16;
  typedef logic [EVT_W-1:0] evt_t;
endpackage

// File: rtl/queue_stream_reader_evt_fifo.sv
// Small synchronous FIFO holding events returned by the SRAM; head is read
// from registered storage so downstream never sees the raw SRAM port.
module evt_fifo
  import queue_stream_reader_pkg::*;
#(
  parameter int DATA_W = EVT_W,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [OCC_W-1:0]  o_occ
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/queue_stream_reader.sv
// Drains the SRAM event queue into a valid/ready stream, issuing reads only
// when FIFO space is guaranteed and never in a queue insert cycle.
module queue_stream_reader
  import queue_stream_reader_pkg::*;
#(
  parameter int DATA_W = EVT_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = queue_stream_reader_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              q_valid_i,
  input  logic              q_insert_i,
  input  logic [DATA_W-1:0] q_data_i,
  output logic              q_read_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int A_W   = $clog2(DEPTH) + 2;

  logic              r_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic [A_W-1:0]    w_level;
  logic              w_room;

  assign m_valid_o = (w_occ != '0);
  assign w_pop     = m_valid_o & m_ready_i;

  // Space check counts the read already in flight and credits this cycle's pop.
  assign w_level  = A_W'(w_occ) + A_W'(r_inflight) - A_W'(w_pop);
  assign w_room   = (w_level < A_W'(DEPTH));
  assign q_read_o = ~rst & en_i & q_valid_i & ~q_insert_i & w_room;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      r_inflight <= q_read_o;
      if (w_pop) r_count <= r_count + 1'b1;
    end
  end

  evt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_data (q_data_i),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign m_data_o = w_head;
  assign busy_o   = r_inflight | m_valid_o;
  assign count_o  = r_count;

endmodule
